// File: rtl/wb_stream_writer.sv
// Memory-to-stream DMA: Wishbone burst reads fill a FWFT FIFO that feeds a
// valid/ready stream; a small Wishbone slave register file controls it.
module wb_stream_writer #(
    parameter int WB_DW         = 32,
    parameter int WB_AW         = 32,
    parameter int FIFO_AW       = 4,
    parameter int MAX_BURST_LEN = 2**FIFO_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [WB_DW-1:0]   wbm_dat_o,
    output logic [WB_DW/8-1:0] wbm_sel_o,
    output logic               wbm_we_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic [2:0]         wbm_cti_o,
    output logic [1:0]         wbm_bte_o,
    input  logic [WB_DW-1:0]   wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    output logic [WB_DW-1:0]   stream_m_data_o,
    output logic               stream_m_valid_o,
    input  logic               stream_m_ready_i,
    output logic               irq_o,
    input  logic [4:0]         wbs_adr_i,
    input  logic [WB_DW-1:0]   wbs_dat_i,
    input  logic [WB_DW/8-1:0] wbs_sel_i,
    input  logic               wbs_we_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic [2:0]         wbs_cti_i,
    input  logic [1:0]         wbs_bte_i,
    output logic [WB_DW-1:0]   wbs_dat_o,
    output logic               wbs_ack_o,
    output logic               wbs_err_o
);
    localparam int DEPTH = 2**FIFO_AW;
    localparam int LIM   = (MAX_BURST_LEN < DEPTH) ? MAX_BURST_LEN : DEPTH;
    localparam int CW    = FIFO_AW + 1;
    localparam int BSH   = $clog2(WB_DW/8);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_BURST, S_DRAIN, S_DONE} state_t;
    state_t r_state, w_next;

    logic               r_enable, r_irq, r_busy, r_err;
    logic [WB_AW-1:0]   r_start_adr;
    logic [WB_DW-1:0]   r_buf_size, r_burst_size, r_tx_cnt;
    logic [CW-1:0]      r_beats;
    logic               r_wbs_ack;
    logic [WB_DW-1:0]   r_wbs_dat, w_rdata;

    logic [WB_DW-1:0]   r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic               w_wbs_req, w_wbs_wr, w_in_burst, w_push, w_pop, w_last;
    logic [WB_DW-1:0]   w_remain, w_bsz, w_min1;
    logic [CW-1:0]      w_len, w_free;
    logic               w_unused;

    assign w_unused   = &{1'b0, wbs_sel_i, wbs_cti_i, wbs_bte_i, wbs_adr_i[1:0]};
    assign w_wbs_req  = wbs_cyc_i & wbs_stb_i & ~r_wbs_ack;
    assign w_wbs_wr   = w_wbs_req & wbs_we_i;
    assign w_in_burst = (r_state == S_BURST);
    assign w_push     = w_in_burst & wbm_ack_i & ~wbm_err_i;
    assign w_pop      = stream_m_valid_o & stream_m_ready_i;
    assign w_last     = (r_beats == CW'(1));

    // Burst length: min(BURST_SIZE (0 means 1), remaining words, LIM)
    assign w_remain = r_buf_size - r_tx_cnt;
    assign w_bsz    = (r_burst_size == '0) ? WB_DW'(1) : r_burst_size;
    assign w_min1   = (w_bsz < w_remain) ? w_bsz : w_remain;
    assign w_len    = (w_min1 < WB_DW'(LIM)) ? CW'(w_min1) : CW'(LIM);
    assign w_free   = CW'(DEPTH) - r_count;

    always_comb begin
        w_next    = r_state;
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_cti_o = 3'b000;
        wbm_adr_o = '0;
        case (r_state)
            S_IDLE:  if (r_enable) w_next = (r_buf_size == '0) ? S_DONE : S_WAIT;
            S_WAIT: begin
                if (!r_enable)           w_next = S_DRAIN;
                else if (w_free >= w_len) w_next = S_BURST;
            end
            S_BURST: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_cti_o = w_last ? 3'b111 : 3'b010;
                wbm_adr_o = r_start_adr + (WB_AW'(r_tx_cnt) << BSH);
                if (wbm_err_i)
                    w_next = S_DRAIN;
                else if (wbm_ack_i && w_last)
                    w_next = ((r_tx_cnt + WB_DW'(1)) < r_buf_size) ? S_WAIT : S_DRAIN;
            end
            S_DRAIN: if (r_count == '0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        case (wbs_adr_i[4:2])
            3'd0: w_rdata = {{(WB_DW-4){1'b0}}, r_err, r_busy, r_irq, r_enable};
            3'd1: w_rdata = WB_DW'(r_start_adr);
            3'd2: w_rdata = r_buf_size;
            3'd3: w_rdata = r_burst_size;
            3'd4: w_rdata = r_tx_cnt;
            default: w_rdata = '0;
        endcase
    end

    // FSM-driven updates come after register writes so a set beats a W1C clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_enable     <= 1'b0;
            r_irq        <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_start_adr  <= '0;
            r_buf_size   <= '0;
            r_burst_size <= '0;
            r_tx_cnt     <= '0;
            r_beats      <= '0;
            r_wbs_ack    <= 1'b0;
            r_wbs_dat    <= '0;
        end else begin
            r_state   <= w_next;
            r_wbs_ack <= w_wbs_req;
            if (w_wbs_req) r_wbs_dat <= w_rdata;
            if (w_wbs_wr) begin
                case (wbs_adr_i[4:2])
                    3'd0: begin
                        r_enable <= wbs_dat_i[0];
                        if (wbs_dat_i[1]) r_irq <= 1'b0;
                        if (wbs_dat_i[3]) r_err <= 1'b0;
                    end
                    3'd1: if (!r_busy) r_start_adr  <= WB_AW'(wbs_dat_i);
                    3'd2: if (!r_busy) r_buf_size   <= wbs_dat_i;
                    3'd3: if (!r_busy) r_burst_size <= wbs_dat_i;
                    default: ;
                endcase
            end
            case (r_state)
                S_IDLE: if (r_enable) begin
                    r_busy   <= 1'b1;
                    r_tx_cnt <= '0;
                end
                S_WAIT: if (w_next == S_BURST) r_beats <= w_len;
                S_BURST: begin
                    if (wbm_err_i) begin
                        r_err <= 1'b1;
                    end else if (wbm_ack_i) begin
                        r_tx_cnt <= r_tx_cnt + WB_DW'(1);
                        r_beats  <= r_beats - CW'(1);
                    end
                end
                S_DONE: begin
                    if (r_enable || r_err) r_irq <= 1'b1;
                    r_enable <= 1'b0;
                    r_busy   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wbm_dat_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (w_pop && !w_push) r_count <= r_count - CW'(1);
        end
    end

    assign stream_m_valid_o = (r_count != '0);
    assign stream_m_data_o  = stream_m_valid_o ? r_mem[r_rd_ptr] : '0;
    assign wbm_dat_o = '0;
    assign wbm_sel_o = '1;
    assign wbm_we_o  = 1'b0;
    assign wbm_bte_o = 2'b00;
    assign irq_o     = r_irq;
    assign wbs_dat_o = r_wbs_dat;
    assign wbs_ack_o = r_wbs_ack;
    assign wbs_err_o = 1'b0;
endmodule

// File: tb/tb_wb_stream_writer.sv
// Directed bench for wb_stream_writer (4-word FIFO): memory responder checks
// burst addresses/cti, stream monitor pops a scoreboard of expected words.
module tb_wb_stream_writer;
    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [31:0] stream_m_data_o;
    logic        stream_m_valid_o, stream_m_ready_i, irq_o;
    logic [4:0]  wbs_adr_i;
    logic [31:0] wbs_dat_i, wbs_dat_o;
    logic [3:0]  wbs_sel_i;
    logic        wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_ack_o, wbs_err_o;
    logic [2:0]  wbs_cti_i;
    logic [1:0]  wbs_bte_i;

    int checks = 0;
    int fails = 0;
    int beat_cnt = 0;
    int err_beat = -1;
    int cyc_seen = 0;
    logic [31:0] exp_adr[$];
    logic [2:0]  exp_cti[$];
    logic [31:0] exp_dat[$];

    wb_stream_writer #(.WB_DW(32), .WB_AW(32), .FIFO_AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .stream_m_data_o(stream_m_data_o), .stream_m_valid_o(stream_m_valid_o),
        .stream_m_ready_i(stream_m_ready_i), .irq_o(irq_o),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
        .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
        .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i), .wbs_dat_o(wbs_dat_o),
        .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'hDEAD_0000 ^ (a * 32'd2654435761);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Expected bus beats and stream words for a transfer from the spec's rules
    task automatic plan(input logic [31:0] start, input int buf_n, input int bsz,
                        input int n_adr, input int n_dat);
        int i, len, b;
        i = 0;
        b = (bsz == 0) ? 1 : bsz;
        while (i < buf_n) begin
            len = (b < MAXB) ? b : MAXB;
            if (buf_n - i < len) len = buf_n - i;
            for (int k = 0; k < len; k++) begin
                if (i < n_adr) begin
                    exp_adr.push_back(start + 32'(i * 4));
                    exp_cti.push_back((k == len - 1) ? 3'b111 : 3'b010);
                end
                if (i < n_dat) exp_dat.push_back(memf(start + 32'(i * 4)));
                i++;
            end
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [4:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
        logic got;
        @(posedge clk); #1;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr;  wbs_dat_i = wdat;
        got = 1'b0;
        rdat = '0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            if (wbs_ack_o) begin
                got = 1'b1;
                rdat = wbs_dat_o;
            end
        end
        check("wbs_ack_seen", 32'(got), 32'd1);
        @(posedge clk); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wr(input logic [4:0] adr, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, d, dummy);
    endtask

    task automatic rd(input logic [4:0] adr, output logic [31:0] d);
        wb_xfer(1'b0, adr, 32'h0, d);
    endtask

    task automatic wait_irq(input string tag, input int max);
        logic got;
        got = 1'b0;
        for (int n = 0; n < max && !got; n++) begin
            @(negedge clk);
            if (irq_o) got = 1'b1;
        end
        check(tag, 32'(got), 32'd1);
    endtask

    task automatic wait_cyc(input string tag, input int max);
        logic got;
        got = 1'b0;
        for (int n = 0; n < max && !got; n++) begin
            @(negedge clk);
            if (wbm_cyc_o) got = 1'b1;
        end
        check(tag, 32'(got), 32'd1);
    endtask

    // Memory responder: zero-wait ack, optional error on a chosen beat
    initial begin
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = '0;
        forever begin
            @(negedge clk);
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            if (wbm_cyc_o && wbm_stb_o) begin
                cyc_seen = 1;
                checks++;
                assert (exp_adr.size() != 0) else begin
                    fails++;
                    $display("FAIL unexpected_beat: observed adr=%h expected=no beat", wbm_adr_o);
                    $error("unexpected beat");
                end
                if (exp_adr.size() != 0) begin
                    check("wbm_adr", wbm_adr_o, exp_adr.pop_front());
                    check("wbm_cti", 32'(wbm_cti_o), 32'(exp_cti.pop_front()));
                end
                if (beat_cnt == err_beat) wbm_err_i = 1'b1;
                else begin
                    wbm_ack_i = 1'b1;
                    wbm_dat_i = memf(wbm_adr_o);
                end
                beat_cnt++;
            end
        end
    end

    // Stream monitor: scoreboard pop on handshake, stability while stalled
    initial begin
        logic        hold;
        logic [31:0] held;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) hold = 1'b0;
            else begin
                if (hold) begin
                    check("hold_valid", 32'(stream_m_valid_o), 32'd1);
                    check("hold_data", stream_m_data_o, held);
                end
                if (stream_m_valid_o && stream_m_ready_i) begin
                    checks++;
                    assert (exp_dat.size() != 0) else begin
                        fails++;
                        $display("FAIL extra_word: observed=%h expected=no word", stream_m_data_o);
                        $error("extra word");
                    end
                    if (exp_dat.size() != 0) check("stream_data", stream_m_data_o, exp_dat.pop_front());
                end
                hold = stream_m_valid_o && !stream_m_ready_i;
                held = stream_m_data_o;
            end
        end
    end

    initial begin
        logic [31:0] v;
        wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = 4'hF; wbs_we_i = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_cti_i = '0; wbs_bte_i = '0;
        stream_m_ready_i = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        check("rst_valid", 32'(stream_m_valid_o), 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        check("rst_sel", 32'(wbm_sel_o), 32'hF);
        check("rst_adr", wbm_adr_o, 32'd0);
        rst_n = 1'b1;
        rd(5'h00, v); check("rst_ctrl", v, 32'd0);
        rd(5'h10, v); check("rst_txcnt", v, 32'd0);

        // T1: two 4-beat bursts, free-running sink
        plan(32'h1000, 8, 4, 8, 8);
        wr(5'h04, 32'h1000); wr(5'h08, 32'd8); wr(5'h0C, 32'd4);
        rd(5'h04, v); check("t1_start_rb", v, 32'h1000);
        wr(5'h00, 32'h1);
        wait_irq("t1_irq", 200);
        check("t1_words_left", 32'(exp_dat.size()), 32'd0);
        check("t1_beats_left", 32'(exp_adr.size()), 32'd0);
        rd(5'h00, v); check("t1_ctrl", v, 32'h2);
        rd(5'h10, v); check("t1_txcnt", v, 32'd8);
        check("w1c_pre", 32'(irq_o), 32'd1);
        wr(5'h00, 32'h2);
        check("w1c_irq", 32'(irq_o), 32'd0);

        // T3: zero-length buffer completes without bus traffic
        cyc_seen = 0;
        wr(5'h08, 32'd0);
        wr(5'h00, 32'h1);
        wait_irq("t3_irq_fast", 3);
        check("t3_no_cyc", 32'(cyc_seen), 32'd0);
        rd(5'h00, v); check("t3_ctrl", v, 32'h2);
        wr(5'h00, 32'h2);

        // T4: bus error on third beat
        beat_cnt = 0; err_beat = 2;
        plan(32'h3000, 8, 4, 3, 2);
        wr(5'h04, 32'h3000); wr(5'h08, 32'd8); wr(5'h0C, 32'd4);
        wr(5'h00, 32'h1);
        wait_irq("t4_irq", 200);
        check("t4_beats", 32'(beat_cnt), 32'd3);
        check("t4_words_left", 32'(exp_dat.size()), 32'd0);
        rd(5'h00, v); check("t4_ctrl", v, 32'hA);
        rd(5'h10, v); check("t4_txcnt", v, 32'd2);
        wr(5'h00, 32'hA);
        rd(5'h00, v); check("t4_ctrl_clr", v, 32'h0);
        err_beat = -1;

        // T5: disable during first burst: burst finishes, no irq
        beat_cnt = 0;
        plan(32'h4000, 16, 4, 4, 4);
        wr(5'h04, 32'h4000); wr(5'h08, 32'd16); wr(5'h0C, 32'd4);
        wr(5'h00, 32'h1);
        wait_cyc("t5_cyc", 40);
        wr(5'h00, 32'h0);
        repeat (30) @(negedge clk);
        check("t5_beats", 32'(beat_cnt), 32'd4);
        check("t5_irq", 32'(irq_o), 32'd0);
        check("t5_words_left", 32'(exp_dat.size()), 32'd0);
        rd(5'h00, v); check("t5_ctrl", v, 32'h0);
        rd(5'h10, v); check("t5_txcnt", v, 32'd4);

        // T2: stalled sink, second single-beat burst waits for FIFO space
        stream_m_ready_i = 1'b0;
        beat_cnt = 0;
        plan(32'h2000, 5, 4, 5, 5);
        wr(5'h04, 32'h2000); wr(5'h08, 32'd5); wr(5'h0C, 32'd4);
        wr(5'h00, 32'h1);
        repeat (20) @(negedge clk);
        check("t2_beats_stalled", 32'(beat_cnt), 32'd4);
        check("t2_valid", 32'(stream_m_valid_o), 32'd1);
        check("t2_head", stream_m_data_o, memf(32'h2000));
        rd(5'h10, v); check("t2_txcnt_stalled", v, 32'd4);
        @(posedge clk); #1;
        stream_m_ready_i = 1'b1;
        wait_irq("t2_irq", 100);
        check("t2_beats", 32'(beat_cnt), 32'd5);
        check("t2_words_left", 32'(exp_dat.size()), 32'd0);

        // T6: asynchronous reset mid-burst with irq still pending
        stream_m_ready_i = 1'b0;
        plan(32'h5000, 8, 4, 8, 0);
        wr(5'h04, 32'h5000); wr(5'h08, 32'd8); wr(5'h0C, 32'd4);
        wr(5'h00, 32'h1);
        wait_cyc("t6_cyc", 40);
        repeat (2) @(negedge clk);
        check("t6_pre_valid", 32'(stream_m_valid_o), 32'd1);
        check("t6_pre_irq", 32'(irq_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_cyc", 32'(wbm_cyc_o), 32'd0);
        check("t6_stb", 32'(wbm_stb_o), 32'd0);
        check("t6_valid", 32'(stream_m_valid_o), 32'd0);
        check("t6_irq", 32'(irq_o), 32'd0);
        exp_adr.delete(); exp_cti.delete(); exp_dat.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        stream_m_ready_i = 1'b1;
        rd(5'h00, v); check("t6_ctrl", v, 32'h0);
        rd(5'h10, v); check("t6_txcnt", v, 32'd0);
        rd(5'h04, v); check("t6_start", v, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/wb_stream_writer.md
Name: wb_stream_writer

Overview:
Memory-to-stream DMA engine. It is the transmit-side counterpart of the stream-to-memory capture path.
- A Wishbone B3 master performs incrementing burst reads from a memory buffer and pushes the words into an internal single-clock FIFO.
- The FIFO drives a valid/ready stream source.
- A small Wishbone slave register file configures the transfer and raises an interrupt on completion.

Parameters:
WB_DW, 32, Wishbone and stream data width (bits).
WB_AW, 32, Wishbone address width (bytes).
FIFO_AW, 4, FIFO depth is 2**FIFO_AW words.
MAX_BURST_LEN, 2**FIFO_AW, upper limit on words per burst.

Ports:
clk  in  1  system clock, all logic.
rst_n  in  1  asynchronous active-low reset.
wbm_adr_o  out  WB_AW  master byte address.
wbm_dat_o  out  WB_DW  tied 0.
wbm_sel_o  out  WB_DW/8  all ones.
wbm_we_o  out  1  tied 0.
wbm_cyc_o / wbm_stb_o  out  1  bus cycle / strobe.
wbm_cti_o  out  3  010 incrementing, 111 last beat.
wbm_bte_o  out  2  tied 00 (linear).
wbm_dat_i  in  WB_DW  read data.
wbm_ack_i / wbm_err_i  in  1  slave ack / error.
stream_m_data_o  out  WB_DW  stream data.
stream_m_valid_o  out  1  stream valid.
stream_m_ready_i  in  1  stream ready.
irq_o  out  1  level interrupt.
wbs_adr_i  in  5  config byte address; bits [4:2] select the register.
wbs_dat_i  in  WB_DW  config write data.
wbs_sel_i  in  WB_DW/8  ignored (full-word access).
wbs_we_i / wbs_cyc_i / wbs_stb_i  in  1  config strobes.
wbs_cti_i / wbs_bte_i  in  3 / 2  ignored.
wbs_dat_o  out  WB_DW  config read data.
wbs_ack_o / wbs_err_o  out  1  ack; err tied 0.

Behaviour:
Reset (rst_n low, asynchronous):
- All registers, counters and FIFO pointers clear to 0.
- All outputs are 0 except wbm_sel_o, which stays all ones.
- FSM goes to IDLE.
- Reset mid-burst drops cyc/stb immediately.

Register map:
- 0x00 CTRL: bit0 enable (RW), bit1 irq (W1C), bit2 busy (RO), bit3 err (W1C).
- 0x04 START_ADR.
- 0x08 BUF_SIZE, in words.
- 0x0C BURST_SIZE, in words.
- 0x10 TX_CNT (RO), words fetched so far.
- Other addresses read 0.
- Writes to 0x04–0x0C while busy=1 are ignored.

Config slave:
- wbs_ack_o pulses 1 cycle after cyc&stb, and deasserts on the following cycle even if stb is held.
- One ack per access.
- Read data is registered and valid alongside the ack.

FSM:
- IDLE: on enable 0→1, clear TX_CNT and set busy. If BUF_SIZE==0, go to DONE. Otherwise go to WAIT.
- WAIT: compute len = min(BURST_SIZE, MAX_BURST_LEN, BUF_SIZE−TX_CNT), with BURST_SIZE==0 treated as 1. When FIFO free space ≥ len, go to BURST. If enable was cleared, go to DRAIN.
- BURST: assert cyc=stb=1 with wbm_adr_o = START_ADR + TX_CNT*(WB_DW/8).
  - Each ack writes wbm_dat_i into the FIFO, increments TX_CNT and advances the address by WB_DW/8.
  - cti=111 on the last beat, including a single-beat burst.
  - After the last ack, drop cyc/stb in the same cycle and go to WAIT if TX_CNT<BUF_SIZE, else DRAIN.
  - err_i terminates the burst without writing the FIFO, sets err, and goes to DRAIN.
- DRAIN: wait until the FIFO is empty, then go to DONE.
- DONE: set irq (only if enable is still 1 or err is set), clear enable and busy, go to IDLE.

Enable and interrupt rules:
- Clearing enable mid-burst: the current burst completes, then the FSM drains and returns to IDLE with no irq.
- irq_o = irq bit. The irq bit stays high until written 1-to-clear. A set on the same cycle as a clear wins.

Address arithmetic:
- Address arithmetic is WB_AW-bit modulo; wrap-around at 2**WB_AW is silent.
- TX_CNT is WB_DW-bit.

FIFO / stream:
- First-word-fall-through FIFO.
- A word acked in cycle N is visible with stream_m_valid_o=1 in cycle N+1.
- While valid=1 and ready=0, data and valid are held stable.
- A word is popped when valid&ready.
- Simultaneous push and pop on a full FIFO is legal.
- The FIFO never overflows: free-space gating guarantees this. Never drop or duplicate a word.

Test Plan:
- START_ADR=0x1000, BUF_SIZE=8, BURST_SIZE=4, ready=1 → two bursts, addresses 0x1000–0x100C then 0x1010–0x101C, cti 010,010,010,111 per burst; stream emits mem[0..7] in order; irq_o=1 after the last word, busy=0, TX_CNT=8.
- BUF_SIZE=5, BURST_SIZE=4, FIFO_AW=2, ready held 0 → first burst of 4 fills the FIFO; second burst (len 1, cti=111) does not start until ready=1 pops a word; all 5 words are delivered in order.
- BUF_SIZE=0 with enable=1 → no wbm_cyc_o ever; irq_o=1 within 3 cycles.
- wbm_err_i on beat 2 of a burst → cyc drops; err=1, irq=1; the stream emits exactly the 2 words acked earlier.
- Clear enable during the first burst of BUF_SIZE=16 → the burst completes, no further bursts, FIFO drains, irq_o stays 0.
- Write CTRL with bit1=1 while irq=1 → irq_o falls the next cycle. rst_n low mid-burst → cyc, valid and irq are 0 asynchronously.
